// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin arbiter sharing two synchronous ROM read ports among NUM_REQ requesters
module rom_port_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
    output logic                             rom_en_a,
    output logic [ADDRESS_WIDTH-1:0]         rom_addr_a,
    input  logic [DATA_WIDTH-1:0]            rom_dout_a,
    output logic                             rom_en_b,
    output logic [ADDRESS_WIDTH-1:0]         rom_addr_b,
    input  logic [DATA_WIDTH-1:0]            rom_dout_b,
    output logic [15:0]                      grant_cnt
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]                  rr_ptr;
    logic                           win_a, win_b;
    logic [IW-1:0]                  id_a, id_b;
    logic [IW-1:0]                  idx;
    int                             sum;
    logic                           fa, fb;
    logic [IW-1:0]                  ida, idb;
    logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_hold;
    logic [16:0]                    cnt_sum;
    logic [IW-1:0]                  last_id;
    logic [IW-1:0]                  ptr_next;

    // Scan from rr_ptr; winners are suppressed during reset so the ROM stays idle.
    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        id_a  = '0;
        id_b  = '0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = IW'(sum);
            if (req_valid[idx] && rst_n) begin
                if (!win_a) begin
                    win_a = 1'b1;
                    id_a  = idx;
                end else if (!win_b) begin
                    win_b = 1'b1;
                    id_b  = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_a) req_ready[id_a] = 1'b1;
        if (win_b) req_ready[id_b] = 1'b1;
        rom_en_a   = win_a;
        rom_en_b   = win_b;
        rom_addr_a = win_a ? req_addr[id_a*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
        rom_addr_b = win_b ? req_addr[id_b*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    end

    always_comb begin
        last_id  = win_b ? id_b : id_a;
        ptr_next = (int'(last_id) == NUM_REQ - 1) ? '0 : last_id + 1'b1;
        cnt_sum  = {1'b0, grant_cnt} + 17'(win_a) + 17'(win_b);
    end

    // ROM words arrive the cycle after the enable, so they are steered straight
    // onto rsp_data that cycle and captured into rsp_hold for later cycles.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = rsp_hold;
        if (fa) begin
            rsp_valid[ida]                       = 1'b1;
            rsp_data[ida*DATA_WIDTH +: DATA_WIDTH] = rom_dout_a;
        end
        if (fb) begin
            rsp_valid[idb]                       = 1'b1;
            rsp_data[idb*DATA_WIDTH +: DATA_WIDTH] = rom_dout_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            fa        <= 1'b0;
            fb        <= 1'b0;
            ida       <= '0;
            idb       <= '0;
            rsp_hold  <= '0;
            grant_cnt <= '0;
        end else begin
            fa        <= win_a;
            fb        <= win_b;
            ida       <= id_a;
            idb       <= id_b;
            rsp_hold  <= rsp_data;
            if (win_a) rr_ptr <= ptr_next;
            grant_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed vector bench for rom_port_arbiter
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rom_en_a, rom_en_b;
    logic [2:0]  rom_addr_a, rom_addr_b;
    logic [7:0]  rom_dout_a, rom_dout_b;
    logic [15:0] grant_cnt;

    logic [7:0]  rom_mem [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDRESS_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rom_en_a   (rom_en_a),
        .rom_addr_a (rom_addr_a),
        .rom_dout_a (rom_dout_a),
        .rom_en_b   (rom_en_b),
        .rom_addr_b (rom_addr_b),
        .rom_dout_b (rom_dout_b),
        .grant_cnt  (grant_cnt)
    );

    always @(posedge clk) begin
        if (rom_en_a) rom_dout_a <= rom_mem[rom_addr_a];
        if (rom_en_b) rom_dout_b <= rom_mem[rom_addr_b];
    end

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] addr;
        logic [3:0]  ready;
        logic        en_a;
        logic [2:0]  addr_a;
        logic        en_b;
        logic [2:0]  addr_b;
        logic [3:0]  rvalid;
        logic [31:0] rdata;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rom_mem[0] = 8'hAA; rom_mem[1] = 8'h55; rom_mem[2] = 8'hFF; rom_mem[3] = 8'hB7;
        rom_mem[4] = 8'h56; rom_mem[5] = 8'h43; rom_mem[6] = 8'h1F; rom_mem[7] = 8'hE2;
        rom_dout_a = '0;
        rom_dout_b = '0;

        vecs[0]  = '{4'b0001, {3'd0,3'd0,3'd0,3'd3}, 4'b0001, 1'b1, 3'd3, 1'b0, 3'd0, 4'b0000, 32'h0000_0000, 16'd0};
        vecs[1]  = '{4'b0000, 12'd0,                 4'b0000, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0001, 32'h0000_00B7, 16'd1};
        vecs[2]  = '{4'b1000, {3'd7,3'd0,3'd0,3'd0}, 4'b1000, 1'b1, 3'd7, 1'b0, 3'd0, 4'b0000, 32'h0000_00B7, 16'd1};
        vecs[3]  = '{4'b1111, {3'd7,3'd2,3'd1,3'd0}, 4'b0011, 1'b1, 3'd0, 1'b1, 3'd1, 4'b1000, 32'hE200_00B7, 16'd2};
        vecs[4]  = '{4'b1100, {3'd7,3'd2,3'd1,3'd0}, 4'b1100, 1'b1, 3'd2, 1'b1, 3'd7, 4'b0011, 32'hE200_55AA, 16'd4};
        vecs[5]  = '{4'b0000, 12'd0,                 4'b0000, 1'b0, 3'd0, 1'b0, 3'd0, 4'b1100, 32'hE2FF_55AA, 16'd6};
        vecs[6]  = '{4'b1010, {3'd5,3'd0,3'd5,3'd0}, 4'b1010, 1'b1, 3'd5, 1'b1, 3'd5, 4'b0000, 32'hE2FF_55AA, 16'd6};
        vecs[7]  = '{4'b1010, {3'd5,3'd0,3'd5,3'd0}, 4'b1010, 1'b1, 3'd5, 1'b1, 3'd5, 4'b1010, 32'h43FF_43AA, 16'd8};
        vecs[8]  = '{4'b1010, {3'd5,3'd0,3'd5,3'd0}, 4'b1010, 1'b1, 3'd5, 1'b1, 3'd5, 4'b1010, 32'h43FF_43AA, 16'd10};
        vecs[9]  = '{4'b0011, {3'd0,3'd0,3'd6,3'd4}, 4'b0011, 1'b1, 3'd4, 1'b1, 3'd6, 4'b1010, 32'h43FF_43AA, 16'd12};
        vecs[10] = '{4'b1001, {3'd2,3'd0,3'd0,3'd1}, 4'b1001, 1'b1, 3'd2, 1'b1, 3'd1, 4'b0011, 32'h43FF_1F56, 16'd14};
        vecs[11] = '{4'b0001, 12'd0,                 4'b0001, 1'b1, 3'd0, 1'b0, 3'd0, 4'b1001, 32'hFFFF_1F55, 16'd16};
        vecs[12] = '{4'b0000, 12'd0,                 4'b0000, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0001, 32'hFFFF_1FAA, 16'd17};

        // reset state, with a request pending to show the ROM stays idle
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        req_addr  = 12'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  rsp_data,       32'h0);
        chk("rst_cnt",       32'(grant_cnt), 32'h0);
        chk("rst_en_a",      32'(rom_en_a),  32'h0);
        chk("rst_addr_a",    32'(rom_addr_a),32'h0);
        chk("rst_ready",     32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            req_valid = vecs[i].valid;
            req_addr  = vecs[i].addr;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i),  32'(req_ready),  32'(vecs[i].ready));
            chk($sformatf("v%0d_en_a", i),   32'(rom_en_a),   32'(vecs[i].en_a));
            chk($sformatf("v%0d_addr_a", i), 32'(rom_addr_a), 32'(vecs[i].addr_a));
            chk($sformatf("v%0d_en_b", i),   32'(rom_en_b),   32'(vecs[i].en_b));
            chk($sformatf("v%0d_addr_b", i), 32'(rom_addr_b), 32'(vecs[i].addr_b));
            chk($sformatf("v%0d_rvalid", i), 32'(rsp_valid),  32'(vecs[i].rvalid));
            chk($sformatf("v%0d_rdata", i),  rsp_data,        vecs[i].rdata);
            chk($sformatf("v%0d_cnt", i),    32'(grant_cnt),  32'(vecs[i].cnt));
        end

        // reset the cycle after an accept: in-flight read discarded
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_addr  = 12'd3;
        @(negedge clk);
        chk("mid_accept", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rsp_data",  rsp_data,       32'h0);
        chk("mid_cnt",       32'(grant_cnt), 32'h0);
        chk("mid_en_a",      32'(rom_en_a),  32'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rel_rsp_valid0", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_rsp_valid1", 32'(rsp_valid), 32'h0);
        chk("rel_rsp_data",   rsp_data,       32'h0);

        // saturation: 32767 cycles of two accepts reach 16'hFFFE
        @(posedge clk); #1;
        req_valid = 4'b1111;
        req_addr  = {3'd3, 3'd2, 3'd1, 3'd0};
        repeat (32767) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", 32'(grant_cnt), 32'h0000_FFFE);
        @(posedge clk);
        @(negedge clk);
        chk("sat_ffff", 32'(grant_cnt), 32'h0000_FFFF);
        @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 32'(grant_cnt), 32'h0000_FFFF);
        req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
